// File: rtl/axi_lite_reg_sequencer.sv
// axi_lite_reg_sequencer: single-outstanding AXI4-Lite master.
// Command/response front end, per-channel handshakes, watchdog flag.
module axi_lite_reg_sequencer #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
  } state_e;

  localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYCLES);

  state_e state_q, state_d;

  logic ready_q, ready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic bready_q, bready_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic [15:0] cnt_q, cnt_d;
  logic to_q, to_d;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, busy;

  assign accept = cmd_valid & ready_q;
  assign aw_hs  = awvalid_q & M_AXI_AWREADY;
  assign w_hs   = wvalid_q & M_AXI_WREADY;
  assign b_hs   = bready_q & M_AXI_BVALID;
  assign ar_hs  = arvalid_q & M_AXI_ARREADY;
  assign r_hs   = rready_q & M_AXI_RVALID;
  assign busy   = (state_q != IDLE) && (state_q != DONE);

  // State and handshake-control registers
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cnt_q       <= '0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
    end
  end

  // Next state; AW and W completions tracked separately
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q | w_hs;
    unique case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (accept) state_d = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ:  if (aw_done_d && w_done_d) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = DONE;
      RD_REQ:  if (ar_hs) state_d = RD_RESP;
      RD_RESP: if (r_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Watchdog: counts busy cycles, saturates and latches the flag
  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (accept) begin
      cnt_d = '0;
      to_d  = 1'b0;
    end else if (busy && (cnt_q != TO_MAX)) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_d == TO_MAX) to_d = 1'b1;
    end
  end

  // Outputs decoded from next state so every output is a flop
  always_comb begin
    ready_d     = (state_d == IDLE);
    awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == WR_REQ) && !w_done_d;
    bready_d    = (state_d == WR_RESP);
    arvalid_d   = (state_d == RD_REQ);
    rready_d    = (state_d == RD_RESP);
    rsp_valid_d = (state_d == DONE);
  end

  // Command latch and response capture
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      resp_q  <= 2'b00;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        strb_q  <= cmd_wstrb;
      end
      if (r_hs) begin
        rdata_q <= M_AXI_RDATA;
        resp_q  <= M_AXI_RRESP;
      end
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= M_AXI_BRESP;
      end
    end
  end

  assign cmd_ready     = ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = to_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = strb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_reg_sequencer.sv
// tb_axi_lite_reg_sequencer: directed bench with a small AXI-Lite
// slave model whose per-channel delays and responses are tunable.
module tb_axi_lite_reg_sequencer;

  logic        clk = 1'b0;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [3:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_lite_reg_sequencer #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(256)
  ) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID),
    .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT),
    .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  // slave model knobs
  int          aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
  logic        frc_en = 1'b0;
  logic [31:0] frc_data = 32'h0;

  logic [31:0] mem [4];
  int          aw_c, w_c, b_c, r_c;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [1:0]  wa, ra;
  logic [31:0] wd;
  logic [3:0]  ws;

  assign AWREADY = AWVALID && (aw_c >= aw_dly);
  assign WREADY  = WVALID && (w_c >= w_dly);
  assign ARREADY = ARVALID;
  assign BVALID  = b_pend && (b_c >= b_dly);
  assign BRESP   = bresp_k;
  assign RVALID  = r_pend && (r_c >= r_dly);
  assign RDATA   = frc_en ? frc_data : mem[ra];
  assign RRESP   = rresp_k;

  always @(posedge clk) begin : slv
    logic a_ok, d_ok;
    logic [1:0] ta;
    logic [31:0] td;
    logic [3:0] ts;
    if (!ARESETN) begin
      aw_c <= 0; w_c <= 0; b_c <= 0; r_c <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      b_pend <= 1'b0; r_pend <= 1'b0;
      wa <= 2'd0; ra <= 2'd0; wd <= '0; ws <= '0;
    end else begin
      aw_c <= (AWVALID && !AWREADY) ? aw_c + 1 : 0;
      w_c  <= (WVALID && !WREADY) ? w_c + 1 : 0;
      a_ok = aw_got || (AWVALID && AWREADY);
      d_ok = w_got || (WVALID && WREADY);
      ta = (AWVALID && AWREADY) ? AWADDR[3:2] : wa;
      td = (WVALID && WREADY) ? WDATA : wd;
      ts = (WVALID && WREADY) ? WSTRB : ws;
      if (a_ok && d_ok) begin
        for (int i = 0; i < 4; i++)
          if (ts[i]) mem[ta][8*i +: 8] <= td[8*i +: 8];
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        b_pend <= 1'b1;
      end else begin
        if (AWVALID && AWREADY) begin
          aw_got <= 1'b1; wa <= AWADDR[3:2];
        end
        if (WVALID && WREADY) begin
          w_got <= 1'b1; wd <= WDATA; ws <= WSTRB;
        end
      end
      b_c <= (b_pend && !(BVALID && BREADY)) ? b_c + 1 : 0;
      if (BVALID && BREADY) b_pend <= 1'b0;
      if (ARVALID && ARREADY) begin
        r_pend <= 1'b1; ra <= ARADDR[3:2];
      end
      r_c <= (r_pend && !(RVALID && RREADY)) ? r_c + 1 : 0;
      if (RVALID && RREADY) r_pend <= 1'b0;
    end
  end

  // monitor: edge numbers of handshakes, per-transaction counters
  int cyc = 0, acc_cnt = 0, acc_cyc = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0;
  int ar_hs_cyc = 0, r_hs_cyc = 0, rsp_cyc = 0, to_cyc = 0;
  int aw_hi = 0, w_hi = 0, br_hi = 0, b_hs_n = 0;
  bit to_seen = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ARESETN && cmd_valid && cmd_ready) begin
      acc_cnt = acc_cnt + 1;
      acc_cyc = cyc;
      aw_hi = 0; w_hi = 0; br_hi = 0; b_hs_n = 0;
      to_seen = 1'b0;
    end else if (rsp_timeout && !to_seen) begin
      to_seen = 1'b1;
      to_cyc = cyc;
    end
    if (AWVALID) aw_hi = aw_hi + 1;
    if (WVALID) w_hi = w_hi + 1;
    if (BREADY) br_hi = br_hi + 1;
    if (AWVALID && AWREADY) aw_hs_cyc = cyc;
    if (WVALID && WREADY) w_hs_cyc = cyc;
    if (BVALID && BREADY) begin
      b_hs_cyc = cyc; b_hs_n = b_hs_n + 1;
    end
    if (ARVALID && ARREADY) ar_hs_cyc = cyc;
    if (RVALID && RREADY) r_hs_cyc = cyc;
    if (rsp_valid) rsp_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int n;
    n = acc_cnt;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && acc_cnt == n; i++) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("accept", 32'(acc_cnt - n), 32'd1);
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rr,
                          output logic to);
    bit got;
    got = 1'b0;
    rd = '0; rr = '0; to = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        got = 1'b1; rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
        break;
      end
    end
    check("rsp_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  logic [31:0] rd;
  logic [1:0]  rr;
  logic        to;
  int          a1, a2, n0;

  initial begin
    ARESETN = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_hs", {27'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    check("rst_rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
    ARESETN = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // write four registers then read them back
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 4'(i * 4), 32'(i + 1), 4'hF);
      wait_rsp(rd, rr, to);
      check("wr_resp", {30'd0, rr}, 32'd0);
      check("wr_rdata0", rd, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 4'(i * 4), 32'd0, 4'h0);
      wait_rsp(rd, rr, to);
      check("rd_data", rd, 32'(i + 1));
      check("rd_resp", {30'd0, rr}, 32'd0);
      check("rd_to", {31'd0, to}, 32'd0);
    end

    // partial strobe write: low two bytes replaced
    issue(1'b1, 4'h0, 32'hFFFF_FFFF, 4'h3);
    wait_rsp(rd, rr, to);
    issue(1'b0, 4'h0, 32'd0, 4'h0);
    wait_rsp(rd, rr, to);
    check("strobe", rd, 32'h0000_FFFF);

    // back-to-back write then read with cmd_valid held high
    repeat (2) @(posedge clk);
    #1;
    n0 = acc_cnt;
    cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'hAA;
    cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    for (int i = 0; i < 20 && acc_cnt == n0; i++) begin
      @(posedge clk); #1;
    end
    a1 = acc_cyc;
    cmd_write = 1'b0; cmd_addr = 4'h8;
    for (int i = 0; i < 20 && acc_cnt == n0 + 1; i++) begin
      @(posedge clk); #1;
    end
    a2 = acc_cyc;
    cmd_valid = 1'b0;
    check("b2b_acc", 32'(acc_cnt - n0), 32'd2);
    check("b2b_gap", 32'(a2 - a1), 32'd4);
    check("b2b_aw", 32'(aw_hs_cyc - a1), 32'd1);
    check("b2b_w", 32'(w_hs_cyc - a1), 32'd1);
    check("b2b_b", 32'(b_hs_cyc - a1), 32'd2);
    check("b2b_wrsp", 32'(rsp_cyc - a1), 32'd3);
    wait_rsp(rd, rr, to);
    @(posedge clk); #1;
    check("b2b_rdata", rd, 32'd3);
    check("b2b_ar", 32'(ar_hs_cyc - a2), 32'd1);
    check("b2b_r", 32'(r_hs_cyc - a2), 32'd2);
    check("b2b_rrsp", 32'(rsp_cyc - a2), 32'd3);

    // AWREADY delayed, WREADY immediate
    aw_dly = 3; w_dly = 0;
    issue(1'b1, 4'hC, 32'h55, 4'hF);
    wait_rsp(rd, rr, to);
    @(posedge clk); #1;
    check("awdly_aw_hi", 32'(aw_hi), 32'd4);
    check("awdly_w_hi", 32'(w_hi), 32'd1);
    check("awdly_aw_hs", 32'(aw_hs_cyc - acc_cyc), 32'd4);
    check("awdly_b_n", 32'(b_hs_n), 32'd1);
    check("awdly_rsp", 32'(rsp_cyc - b_hs_cyc), 32'd1);

    // WREADY delayed, AWREADY immediate
    aw_dly = 0; w_dly = 3;
    issue(1'b1, 4'hC, 32'h66, 4'hF);
    wait_rsp(rd, rr, to);
    @(posedge clk); #1;
    check("wdly_aw_hi", 32'(aw_hi), 32'd1);
    check("wdly_w_hi", 32'(w_hi), 32'd4);
    check("wdly_w_hs", 32'(w_hs_cyc - acc_cyc), 32'd4);
    check("wdly_b_n", 32'(b_hs_n), 32'd1);
    check("wdly_rsp", 32'(rsp_cyc - b_hs_cyc), 32'd1);
    w_dly = 0;

    // BVALID withheld 300 cycles: watchdog fires, write still completes
    b_dly = 300; bresp_k = 2'b11;
    issue(1'b1, 4'h4, 32'h77, 4'hF);
    wait_rsp(rd, rr, to);
    check("to_bresp", {30'd0, rr}, 32'd3);
    check("to_flag", {31'd0, to}, 32'd1);
    check("to_rise", 32'(to_cyc - acc_cyc), 32'd257);
    check("to_b_hs", 32'(b_hs_cyc - acc_cyc), 32'd302);
    check("to_bready", 32'(br_hi), 32'd301);
    b_dly = 0; bresp_k = 2'b00;
    issue(1'b0, 4'h4, 32'd0, 4'h0);
    check("to_clear", {31'd0, rsp_timeout}, 32'd0);
    wait_rsp(rd, rr, to);
    check("to_rd", rd, 32'h77);

    // error response on read
    frc_en = 1'b1; frc_data = 32'hDEAD_BEEF; rresp_k = 2'b10;
    issue(1'b0, 4'h0, 32'd0, 4'h0);
    wait_rsp(rd, rr, to);
    check("err_rdata", rd, 32'hDEAD_BEEF);
    check("err_rresp", {30'd0, rr}, 32'd2);
    frc_en = 1'b0; rresp_k = 2'b00;

    // reset pulse while in RD_RESP
    r_dly = 10;
    issue(1'b0, 4'hC, 32'd0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rready", {31'd0, RREADY}, 32'd1);
    ARESETN = 1'b0;
    @(posedge clk); #1;
    check("mid_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_hs", {27'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    check("mid_rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
    check("mid_rdata", rsp_rdata, 32'd0);
    check("mid_resp", {30'd0, rsp_resp}, 32'd0);
    check("mid_addr", {24'd0, ARADDR, AWADDR}, 32'd0);
    check("mid_wdata", WDATA, 32'd0);
    check("mid_wstrb", {28'd0, WSTRB}, 32'd0);
    ARESETN = 1'b1;
    r_dly = 0;
    @(posedge clk); #1;
    check("mid_ready_rel", {31'd0, cmd_ready}, 32'd1);
    issue(1'b0, 4'h8, 32'd0, 4'h0);
    wait_rsp(rd, rr, to);
    check("post_rst_rd", rd, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_sequencer.md
# axi_lite_reg_sequencer

AXI4-Lite master-side sequencer that turns a simple single-beat command/response interface into fully handshaken AXI4-Lite write and read transactions. It sits between firmware-side control logic (state machines and register shadow loaders) and the AXI-Lite generic register slave, and serialises accesses so that exactly one transaction is outstanding at a time. A watchdog flags transactions the slave fails to complete.

## Interface
Parameters:
- ADDR_WIDTH, 4: AXI address width (byte address; 4 × 32-bit registers).
- DATA_WIDTH, 32: AXI data width; only 32 is supported.
- TIMEOUT_CYCLES, 256: number of cycles from issue without completion before `rsp_timeout` is raised; legal range 2..65535.

Ports:
- ACLK  in  1  single clock; all logic is on its rising edge.
- ARESETN  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on `cmd_valid & cmd_ready`.
- cmd_write  in  1  1 = write, 0 = read; sampled at acceptance.
- cmd_addr  in  ADDR_WIDTH  byte address; sampled at acceptance.
- cmd_wdata  in  DATA_WIDTH  write data; sampled at acceptance.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes; sampled at acceptance.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data; valid with `rsp_valid` when the command was a read, 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the completed transaction.
- rsp_timeout  out  1  sticky watchdog flag; cleared on the next command acceptance.
- M_AXI_AW{ADDR,PROT,VALID,READY}  out,out,out,in  ADDR_WIDTH,3,1,1  write address channel; PROT is fixed at 0.
- M_AXI_W{DATA,STRB,VALID,READY}  out,out,out,in  DATA_WIDTH,DATA_WIDTH/8,1,1  write data channel.
- M_AXI_B{RESP,VALID,READY}  in,in,out  2,1,1  write response channel.
- M_AXI_AR{ADDR,PROT,VALID,READY}  out,out,out,in  ADDR_WIDTH,3,1,1  read address channel; PROT is fixed at 0.
- M_AXI_R{DATA,RESP,VALID,READY}  in,in,in,out  DATA_WIDTH,2,1,1  read data channel.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: `cmd_ready`=1. On acceptance, latch the address, data, strobes and write flag. Go to WR_REQ if writing, otherwise RD_REQ. Clear `rsp_timeout` and the watchdog counter.
- WR_REQ: assert AWVALID and WVALID together. Each is dropped independently, on the cycle after its own handshake. Both handshakes may complete in the same cycle or in either order. Leave for WR_RESP once both have completed.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and go to DONE.
- RD_REQ: ARVALID=1 until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA and RRESP, then go to DONE.
- DONE: `rsp_valid`=1 for one cycle, then go to IDLE.
- A VALID is never withdrawn before its handshake. Timeout does not abort the transaction.
- Watchdog: 16-bit counter that increments in every non-IDLE, non-DONE state. When it reaches TIMEOUT_CYCLES, set `rsp_timeout` (sticky) and saturate the counter. The transaction continues to wait for the slave.
- Address, data and strobe outputs hold their latched values while the corresponding VALID is high.

## Timing
- Reset (`ARESETN`=0 at a clock edge): state=IDLE. All VALID and READY outputs = 0. `rsp_valid`=0, `rsp_rdata`=0, `rsp_resp`=0, `rsp_timeout`=0, and all address/data/strobe outputs = 0. This applies at any point, including mid-transaction.
- `cmd_ready`=1 on the first cycle after reset is released.
- Acceptance at edge N: AWVALID/WVALID (or ARVALID) are high from N+1.
- Zero-wait slave, write: AWREADY/WREADY at N+1, BVALID at N+2. `rsp_valid` at N+3, and a new command can be accepted at N+4.
- Zero-wait slave, read: ARREADY at N+1, RVALID at N+2, `rsp_valid` at N+3.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Write sequence 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC with wstrb=0xF, then read all four back -> four read `rsp_valid` pulses with rdata 0x1..0x4 and `rsp_resp`=0. `rsp_timeout` stays 0.
- Slave delays AWREADY by 3 cycles with WREADY immediate, then the reverse case -> each VALID drops independently. Exactly one B handshake occurs, and `rsp_valid` comes 1 cycle after it.
- Zero-wait slave with `cmd_valid` held high for back-to-back write then read -> acceptances 4 cycles apart, and AXI cycle-level latency matches Timing.
- Slave withholds BVALID for 300 cycles with TIMEOUT_CYCLES=256 -> `rsp_timeout` rises 256 cycles after issue. BREADY remains high, the completion still produces `rsp_valid` with the captured BRESP, and the flag clears on the next acceptance.
- Slave returns RRESP=2'b10 with RDATA=0xDEADBEEF -> `rsp_resp`=2'b10 and `rsp_rdata`=0xDEADBEEF.
- Assert ARESETN low for 1 cycle while in RD_RESP -> all outputs take their reset values at the next edge, and `cmd_ready`=1 one cycle after release.
